// File: rtl/demux_pkg.sv
// Shared constants and types for the 1x4 dispatch demux.
package demux_pkg;

  localparam int NUM_CH    = 4;
  localparam int SEL_W     = 2;
  localparam int DEF_WIDTH = 8;

  typedef logic [SEL_W-1:0] sel_t;

  // Round-robin successor; the 2-bit width gives the 3 -> 0 wrap for free.
  function automatic sel_t next_ptr(input sel_t p);
    return p + sel_t'(1);
  endfunction

endpackage

// File: rtl/demux_1x4.sv
// Combinational 1x4 demux: routes an enable onto one of four one-hot lines.
module demux_1x4
  import demux_pkg::*;
(
  input  logic              i_en,
  input  sel_t              i_sel,
  output logic [NUM_CH-1:0] o_y
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_line
      // Line gi is driven only when enabled and selected.
      assign o_y[gi] = i_en & (i_sel == sel_t'(gi));
    end
  endgenerate

endmodule

// File: rtl/demux_chan_reg.sv
// One output channel: a single data register with its valid flag.
module demux_chan_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Load wins over drain so a same-cycle drain+load keeps valid high with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/demux_dispatch_1x4.sv
// 1-to-4 dispatcher: one upstream stream, four single-entry output channels,
// destination chosen by s or by an internal round-robin pointer.
module demux_dispatch_1x4
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        s,
  input  logic                    rr_en,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [SEL_W-1:0]        rr_ptr,
  output logic                    idle
);

  sel_t              r_rr_ptr;
  sel_t              w_dest;
  logic              w_accept;
  logic [NUM_CH-1:0] w_load;
  logic [NUM_CH-1:0] w_valid;

  // Destination follows rr_en immediately; the pointer itself is untouched by toggling.
  assign w_dest   = rr_en ? r_rr_ptr : s;
  // Space exists if the target is empty or emptying this cycle; never during reset.
  assign in_ready = ~rst & (~w_valid[w_dest] | out_ready[w_dest]);
  assign w_accept = in_valid & in_ready;

  demux_1x4 u_demux (
    .i_en  (w_accept),
    .i_sel (w_dest),
    .o_y   (w_load)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      demux_chan_reg #(.WIDTH(WIDTH)) u_chan (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load[gi]),
        .i_data  (in_data),
        .i_ready (out_ready[gi]),
        .o_valid (w_valid[gi]),
        .o_data  (out_data[gi*WIDTH +: WIDTH])
      );
    end
  endgenerate

  // Round-robin pointer advances only on accepts made in round-robin mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_accept && rr_en) begin
      r_rr_ptr <= next_ptr(r_rr_ptr);
    end
  end

  assign out_valid = w_valid;
  assign rr_ptr    = r_rr_ptr;
  assign idle      = rst | ~(|w_valid);

endmodule

// File: tb/tb_demux_dispatch_1x4.sv
// Self-checking bench: per-channel queue model checked every cycle, plus directed literal checks.
module tb_demux_dispatch_1x4;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    s;
  logic          rr_en;
  logic [4*W-1:0] out_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [1:0]    rr_ptr;
  logic          idle;

  int n_total = 0;
  int n_pass  = 0;

  demux_dispatch_1x4 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .rr_en     (rr_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rr_ptr    (rr_ptr),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Model: each channel is a queue holding at most one word; pointer is a plain int.
  logic [W-1:0] chq[4][$];
  int m_ptr = 0;

  function automatic int m_dest();
    return rr_en ? m_ptr : int'(s);
  endfunction

  function automatic bit m_ready();
    int d;
    d = m_dest();
    return !rst && (chq[d].size() == 0 || out_ready[d]);
  endfunction

  always @(posedge clk) begin
    int d;
    bit acc;
    if (rst) begin
      for (int k = 0; k < 4; k++) chq[k].delete();
      m_ptr = 0;
    end else begin
      d   = m_dest();
      acc = in_valid && m_ready();
      for (int k = 0; k < 4; k++)
        if (chq[k].size() != 0 && out_ready[k]) void'(chq[k].pop_front());
      if (acc) begin
        chq[d].push_back(in_data);
        $display("accept ch=%0d data=%02h rr_en=%0d", d, in_data, rr_en);
        if (rr_en) m_ptr = (m_ptr + 1) % 4;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [3:0] ev;
    bit all_empty;
    ev = '0;
    all_empty = 1;
    for (int k = 0; k < 4; k++) begin
      ev[k] = (chq[k].size() != 0);
      if (ev[k]) begin
        all_empty = 0;
        check($sformatf("m_data%0d", k), 32'(out_data[k*W +: W]), 32'(chq[k][0]));
      end
    end
    check("m_out_valid", 32'(out_valid), 32'(ev));
    check("m_in_ready", 32'(in_ready), 32'(m_ready()));
    check("m_rr_ptr", 32'(rr_ptr), 32'(m_ptr));
    check("m_idle", 32'(idle), 32'(rst || all_empty));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] ch(input int k);
    return out_data[k*W +: W];
  endfunction

  initial begin
    rst = 1; in_valid = 1; in_data = 8'h00; s = 2'd0; rr_en = 0; out_ready = 4'h0;
    // Reset behaviour
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    tick();
    rst = 0; in_valid = 0;
    #1;
    check("post_rst_idle", 32'(idle), 32'd1);
    check("post_rst_valid", 32'(out_valid), 32'h0);

    // Single word to channel 2, then backpressure on s=2
    s = 2'd2; in_data = 8'hA5; in_valid = 1;
    #1;
    check("a5_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 0;
    #1;
    check("a5_valid", 32'(out_valid), 32'b0100);
    check("a5_data", 32'(ch(2)), 32'hA5);
    check("a5_full_ready", 32'(in_ready), 32'd0);
    out_ready = 4'hF; tick(); out_ready = 4'h0;

    // Round-robin: five words to channels 0,1,2,3,0
    rr_en = 1; out_ready = 4'hF; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'h10 + i);
      tick();
      #1;
      check($sformatf("rr_valid%0d", i), 32'(out_valid), 32'(4'b0001 << (i % 4)));
      check($sformatf("rr_data%0d", i), 32'(ch(i % 4)), 32'(8'h10 + i));
    end
    check("rr_ptr_end", 32'(rr_ptr), 32'd1);
    in_valid = 0; tick(); out_ready = 4'h0;

    // Same-cycle drain and reload on channel 1
    rr_en = 0; s = 2'd1; in_data = 8'h33; in_valid = 1;
    tick();
    out_ready = 4'b0010; in_data = 8'h44;
    #1;
    check("bb_in_ready", 32'(in_ready), 32'd1);
    check("bb_old_data", 32'(ch(1)), 32'h33);
    tick();
    in_valid = 0; out_ready = 4'h0;
    #1;
    check("bb_valid", 32'(out_valid[1]), 32'd1);
    check("bb_new_data", 32'(ch(1)), 32'h44);
    out_ready = 4'b0010; tick(); out_ready = 4'h0;

    // Channel 3 full and stalled: word stays upstream for 10 cycles
    s = 2'd3; in_data = 8'h77; in_valid = 1;
    tick();
    in_data = 8'h88;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("stall_ready%0d", i), 32'(in_ready), 32'd0);
      check($sformatf("stall_data%0d", i), 32'(ch(3)), 32'h77);
      check($sformatf("stall_valid%0d", i), 32'(out_valid), 32'b1000);
      tick();
    end
    out_ready = 4'b1000;
    #1;
    check("unstall_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 0; out_ready = 4'h0;
    #1;
    check("unstall_data", 32'(ch(3)), 32'h88);
    check("unstall_valid", 32'(out_valid), 32'b1000);
    out_ready = 4'hF; tick(); out_ready = 4'h0;

    // Build 3 valid channels with rr_ptr=2, then reset mid-stream
    rr_en = 1; in_valid = 1; in_data = 8'hC1; tick();       // ch1, ptr -> 2
    rr_en = 0; s = 2'd0; in_data = 8'hC0; tick();           // ch0
    s = 2'd3; in_data = 8'hC3; tick();                      // ch3
    in_valid = 0;
    #1;
    check("pre_rst_valid", 32'(out_valid), 32'b1011);
    check("pre_rst_ptr", 32'(rr_ptr), 32'd2);
    rst = 1; in_valid = 1; rr_en = 1;
    tick();
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_ptr", 32'(rr_ptr), 32'd0);
    check("mid_rst_idle", 32'(idle), 32'd1);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    rst = 0; in_data = 8'h5A;
    #1;
    check("after_rst_idle", 32'(idle), 32'd1);
    tick();
    in_valid = 0;
    #1;
    check("first_rr_valid", 32'(out_valid), 32'b0001);
    check("first_rr_data", 32'(ch(0)), 32'h5A);
    out_ready = 4'hF; tick();

    // Random stress, checked by the every-cycle model comparison
    for (int i = 0; i < 1500; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      s         = 2'($urandom_range(0, 3));
      rr_en     = 1'($urandom_range(0, 1));
      out_ready = 4'($urandom_range(0, 15));
      tick();
    end
    in_valid = 0; out_ready = 4'hF;
    tick(); tick();
    #1;
    check("final_idle", 32'(idle), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/demux_dispatch_1x4.md
DEMUX_DISPATCH_1X4 -- requirements
Module: demux_dispatch_1x4

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, which sets the data width per channel.
REQ-002 The module SHALL have a single clock and a synchronous active-high reset, with ports clk (input, 1, rising-edge clock) and rst (input, 1, reset).
REQ-003 in_data  input  WIDTH  upstream data word.
REQ-004 in_valid  input  1  upstream word present.
REQ-005 in_ready  output  1  module accepts the word this cycle.
REQ-006 s  input  2  destination channel, used when rr_en=0.
REQ-007 rr_en  input  1  1 selects round-robin destination; 0 selects s.
REQ-008 out_data  output  4*WIDTH  channel k data occupies bits [k*WIDTH +: WIDTH].
REQ-009 out_valid  output  4  per-channel word present.
REQ-010 out_ready  input  4  per-channel downstream accept.
REQ-011 rr_ptr  output  2  current round-robin destination.
REQ-012 idle  output  1  high when all out_valid bits are 0.

Function
REQ-013 dest SHALL be rr_ptr when rr_en=1, else s, evaluated combinationally every cycle.
REQ-014 Each channel k SHALL hold one entry: a data register plus a valid flag.
REQ-015 in_ready SHALL be ~out_valid[dest] | out_ready[dest], with no dependence on in_valid.
REQ-016 An accept SHALL occur when in_valid & in_ready; in_data then loads channel dest and sets out_valid[dest] at the next edge, giving a latency of 1 cycle.
REQ-017 A channel drain SHALL occur when out_valid[k] & out_ready[k]; with no accept to k in the same cycle, out_valid[k] clears at the next edge.
REQ-018 On a simultaneous drain and accept on the same channel, out_valid SHALL stay 1 and the data SHALL take the new word, with no bubble.
REQ-019 Drains on non-dest channels SHALL proceed independently in the same cycle as an accept.
REQ-020 out_data[k] SHALL stay unchanged while out_valid[k]=1 and out_ready[k]=0.
REQ-021 rr_ptr SHALL increment by 1 on each accept while rr_en=1, wrapping from 3 to 0.
REQ-022 rr_ptr SHALL hold while rr_en=0 or while no accept occurs.
REQ-023 Toggling rr_en SHALL take effect in the same cycle, and SHALL NOT modify rr_ptr.
REQ-024 When a channel is full and not draining, the word SHALL remain upstream (in_ready=0); it SHALL NOT be redirected to another channel, and no data SHALL be dropped or duplicated.
REQ-025 Data width arithmetic SHALL be pass-through only, with no truncation or extension.

Reset
REQ-026 While rst=1 at a rising edge, the module SHALL set out_valid=4'b0000, out_data=0, and rr_ptr=0.
REQ-027 While rst=1, in_ready SHALL be 0 and no accept SHALL occur.
REQ-028 A reset asserted mid-stream SHALL discard all held words; the first accept after reset SHALL go to channel 0 in round-robin mode.
REQ-029 idle SHALL be 1 during reset and in the first cycle after reset.

Structure
REQ-030 A shared package demux_pkg SHALL hold NUM_CH=4, SEL_W=2, and the default WIDTH=8.
REQ-031 The per-channel register-plus-valid logic SHALL be one sub-module, demux_chan_reg, instantiated 4 times.
REQ-032 Destination decoding SHALL reuse the team's existing combinational 1x4 demux to form the per-channel load enables.

Verification
REQ-033 After reset, s=2, rr_en=0, in_data=0xA5 for 1 cycle, all out_ready=0 -> the next cycle shows out_valid=4'b0100 and out_data[2]=0xA5; in_ready then drops to 0 while s=2.
REQ-034 With rr_en=1, 5 back-to-back words 0x10..0x14 and out_ready=4'b1111 -> channels 0,1,2,3,0 receive them in order, and rr_ptr ends at 1.
REQ-035 Channel 1 holds 0x33 with out_ready[1]=1; in the same cycle an accept of 0x44 with s=1 -> out_valid[1] stays 1, out_data[1]=0x44, and in_ready stays 1.
REQ-036 Channel 3 is full, out_ready[3]=0, s=3, in_valid=1 -> in_ready=0 for 10 cycles, out_data[3] is unchanged, and no other channel loads; raising out_ready[3] makes the accept occur that cycle.
REQ-037 rst is asserted with 3 channels valid and rr_ptr=2 -> the next edge shows out_valid=0, rr_ptr=0, and idle=1.
REQ-038 A random stress run with random valid/ready, s, and rr_en, checked against a scoreboard -> every accepted word appears exactly once on the correct channel, in order per channel.
